// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state encoding, default width and counter-width helper live here.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter must be at least one bit wide even when WIDTH is 1.
   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full-subtractor cell, iterated by serial_subtractor once per bit.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB first, one bit per clock,
// through a single full_sub cell, and reports borrow and signed overflow.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bin_q, bin_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             cell_x, cell_y, cell_d, cell_bout;
   logic [WIDTH-1:0] res_shift;

   // Operands stay in place; the counter selects the bit under process so the
   // MSBs remain available for the overflow check at the end.
   assign cell_x = a_q[cnt_q];
   assign cell_y = b_q[cnt_q];

   full_sub u_full_sub (
      .x    (cell_x),
      .y    (cell_y),
      .bin  (bin_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign res_shift[gi] = res_q[gi + 1];
      end
   endgenerate
   assign res_shift[WIDTH-1] = cell_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      bin_d   = bin_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               bin_d   = borrow_in;
               cnt_d   = '0;
               res_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy  = 1'b1;
            res_d = res_shift;
            bin_d = cell_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               diff_d  = res_shift;
               bout_d  = cell_bout;
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (cell_d ^ a_q[WIDTH-1]);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         bin_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         bin_q   <= bin_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign diff       = diff_q;
   assign borrow_out = bout_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 with a result scoreboard.
module tb_serial_subtractor;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       borrow_in;
   logic [7:0] diff;
   logic       borrow_out;
   logic       overflow;
   logic       busy;
   logic       done;

   int   n_checks = 0;
   int   n_errors = 0;
   res_t sb[$];
   logic [7:0] prev_diff;

   // run_op results
   int         r_lat, r_bc, r_dc;
   logic       r_to;
   res_t       r_obs;
   logic [7:0] r_mid_diff;
   logic [7:0] r_snap_diff;
   logic [3:0] r_snap_flags;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .busy       (busy),
      .done       (done)
   );

   function automatic res_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      logic [8:0] full;
      res_t       r;
      full   = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
      r.diff = full[7:0];
      r.bout = full[8];
      r.ovf  = (av[7] != bv[7]) && (r.diff[7] != av[7]);
      return r;
   endfunction

   // Called at a negedge with the DUT idle; drives one request and follows it
   // until busy drops, optionally injecting a stray start or a reset.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input int inj_cyc, input int rst_cyc);
      r_lat = -1; r_bc = 0; r_dc = 0; r_to = 1'b1;
      r_obs = '0; r_mid_diff = '0; r_snap_diff = '0; r_snap_flags = '0;
      start = 1'b1; a = av; b = bv; borrow_in = bi;
      sb.push_back(model(av, bv, bi));
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (busy) r_bc++;
         if (done) begin
            if (r_dc == 0) r_lat = cyc;
            r_dc++;
            r_obs.diff = diff; r_obs.bout = borrow_out; r_obs.ovf = overflow;
         end
         if (cyc == 4) r_mid_diff = diff;
         if (cyc == rst_cyc + 1) begin
            r_snap_diff  = diff;
            r_snap_flags = {borrow_out, overflow, busy, done};
            rst = 1'b0;
         end
         if (cyc == 0) begin
            a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
         end
         if (cyc == inj_cyc) begin
            start = 1'b1; a = 8'hFF; b = 8'h00; borrow_in = 1'b0;
         end
         if (cyc == inj_cyc + 1) start = 1'b0;
         if (cyc == rst_cyc) rst = 1'b1;
         if (!busy && cyc > 0) begin
            r_to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; borrow_in = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({diff, borrow_out, overflow, busy, done} !== 12'h000) begin
         n_errors++;
         $display("FAIL reset_outputs: got diff=%h bo=%b ov=%b busy=%b done=%b, need all 0",
                  diff, borrow_out, overflow, busy, done);
      end
      rst = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done);
      end
      prev_diff = 8'h00;
      $display("reset: diff=%h busy=%b", diff, busy);
   endtask

   task automatic test_basic();
      res_t exp;
      @(negedge clk);
      run_op(8'h5A, 8'h23, 1'b0, 100, 100);
      exp = sb.pop_front();
      $display("op 5A-23: diff=%h bo=%b ov=%b lat=%0d busy=%0d", r_obs.diff, r_obs.bout, r_obs.ovf, r_lat, r_bc);
      n_checks++;
      if (r_to) begin n_errors++; $display("FAIL basic_timeout: busy never dropped"); end
      n_checks++;
      if (r_lat !== 8) begin n_errors++; $display("FAIL basic_latency: got %0d, need 8", r_lat); end
      n_checks++;
      if (r_bc !== 9) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d, need 9", r_bc); end
      n_checks++;
      if (r_dc !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d, need 1", r_dc); end
      n_checks++;
      if (r_obs !== exp || exp.diff !== 8'h37) begin
         n_errors++;
         $display("FAIL basic_result: got %h/%b/%b, need 37/0/0", r_obs.diff, r_obs.bout, r_obs.ovf);
      end
      n_checks++;
      if (r_mid_diff !== prev_diff) begin
         n_errors++;
         $display("FAIL basic_hold_during: got %h, need %h", r_mid_diff, prev_diff);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (diff !== 8'h37 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_hold_after: got %h/%b/%b, need 37/0/0", diff, borrow_out, overflow);
      end
      prev_diff = exp.diff;
   endtask

   task automatic test_vectors();
      logic [7:0] ta [6] = '{8'h00, 8'h80, 8'h10, 8'hFF, 8'h7F, 8'h01};
      logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'h01};
      logic       tbi[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      res_t exp;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         run_op(ta[i], tb[i], tbi[i], 100, 100);
         exp = sb.pop_front();
         $display("op %h-%h-%b: diff=%h bo=%b ov=%b", ta[i], tb[i], tbi[i], r_obs.diff, r_obs.bout, r_obs.ovf);
         n_checks++;
         if (r_dc !== 1 || r_lat !== 8) begin
            n_errors++;
            $display("FAIL vec%0d_timing: got done=%0d lat=%0d, need 1 8", i, r_dc, r_lat);
         end
         n_checks++;
         if (r_obs !== exp) begin
            n_errors++;
            $display("FAIL vec%0d_result: got %h/%b/%b, need %h/%b/%b", i,
                     r_obs.diff, r_obs.bout, r_obs.ovf, exp.diff, exp.bout, exp.ovf);
         end
         prev_diff = exp.diff;
      end
   endtask

   task automatic test_start_ignored();
      res_t exp;
      int   extra_done;
      @(negedge clk);
      run_op(8'h5A, 8'h23, 1'b0, 3, 100);
      exp = sb.pop_front();
      $display("op 5A-23 with stray start: diff=%h done_pulses=%0d", r_obs.diff, r_dc);
      n_checks++;
      if (r_dc !== 1 || r_lat !== 8) begin
         n_errors++;
         $display("FAIL ignore_timing: got done=%0d lat=%0d, need 1 8", r_dc, r_lat);
      end
      n_checks++;
      if (r_obs !== exp) begin
         n_errors++;
         $display("FAIL ignore_result: got %h/%b/%b, need %h/%b/%b",
                  r_obs.diff, r_obs.bout, r_obs.ovf, exp.diff, exp.bout, exp.ovf);
      end
      n_checks++;
      if (r_mid_diff !== prev_diff) begin
         n_errors++;
         $display("FAIL ignore_hold_during: got %h, need %h", r_mid_diff, prev_diff);
      end
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      n_checks++;
      if (extra_done !== 0) begin
         n_errors++;
         $display("FAIL ignore_no_second_op: got %0d busy cycles, need 0", extra_done);
      end
      prev_diff = exp.diff;
   endtask

   task automatic test_reset_mid();
      res_t exp;
      @(negedge clk);
      run_op(8'h5A, 8'h23, 1'b0, 100, 4);
      void'(sb.pop_front());
      $display("op 5A-23 aborted by reset: done_pulses=%0d diff=%h", r_dc, r_snap_diff);
      n_checks++;
      if (r_dc !== 0) begin n_errors++; $display("FAIL abort_done: got %0d pulses, need 0", r_dc); end
      n_checks++;
      if (r_snap_diff !== 8'h00 || r_snap_flags !== 4'h0) begin
         n_errors++;
         $display("FAIL abort_outputs: got diff=%h flags=%b, need 00 0000", r_snap_diff, r_snap_flags);
      end
      // Start on the very first edge after rst deasserts.
      run_op(8'h5A, 8'h23, 1'b0, 100, 100);
      exp = sb.pop_front();
      $display("op 5A-23 after reset: diff=%h bo=%b ov=%b", r_obs.diff, r_obs.bout, r_obs.ovf);
      n_checks++;
      if (r_dc !== 1 || r_lat !== 8) begin
         n_errors++;
         $display("FAIL abort_restart_timing: got done=%0d lat=%0d, need 1 8", r_dc, r_lat);
      end
      n_checks++;
      if (r_obs !== exp || exp.diff !== 8'h37) begin
         n_errors++;
         $display("FAIL abort_restart_result: got %h/%b/%b, need 37/0/0", r_obs.diff, r_obs.bout, r_obs.ovf);
      end
      prev_diff = exp.diff;
   endtask

   task automatic test_back_to_back();
      res_t       exp;
      logic [7:0] av, bv;
      logic       bi;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
         run_op(av, bv, bi, 100, 100);
         exp = sb.pop_front();
         $display("op %h-%h-%b: diff=%h bo=%b ov=%b", av, bv, bi, r_obs.diff, r_obs.bout, r_obs.ovf);
         n_checks++;
         if (r_dc !== 1 || r_lat !== 8 || r_to) begin
            n_errors++;
            $display("FAIL b2b%0d_timing: got done=%0d lat=%0d, need 1 8", i, r_dc, r_lat);
         end
         n_checks++;
         if (r_obs !== exp) begin
            n_errors++;
            $display("FAIL b2b%0d_result: got %h/%b/%b, need %h/%b/%b", i,
                     r_obs.diff, r_obs.bout, r_obs.ovf, exp.diff, exp.bout, exp.ovf);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
      prev_diff = 8'h00;
      test_reset();
      test_basic();
      test_vectors();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      n_checks++;
      if (sb.size() !== 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty: got %0d entries left, need 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; operands sampled on the edge where start=1 and the block is in IDLE.
REQ-005 a  input  WIDTH  minuend.
REQ-006 b  input  WIDTH  subtrahend.
REQ-007 borrow_in  input  1  initial borrow, for chaining.
REQ-008 diff  output  WIDTH  result, a - b - borrow_in, modulo 2^WIDTH.
REQ-009 borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned).
REQ-010 overflow  output  1  signed overflow of the two's-complement subtraction.
REQ-011 busy  output  1  high in SHIFT and DONE.
REQ-012 done  output  1  one-cycle pulse; result outputs valid.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1: load a, b and borrow_in into internal registers; clear the bit counter to 0; go to SHIFT.
REQ-015 IDLE with start=0: remain in IDLE.
REQ-016 SHIFT: process one bit per cycle, LSB first, through the full-subtractor cell.
  - d = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)
  - shift d into the result register; register bout as the next bin.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; the FSM moves to DONE on the edge that processes bit WIDTH-1.
REQ-018 done SHALL be 1 only in DONE, i.e. the cycle that starts WIDTH edges after the start-sampling edge; DONE always returns to IDLE on the next edge.
REQ-019 diff, borrow_out and overflow SHALL be updated only on the edge entering DONE, and SHALL hold until the next entry into DONE or reset.
REQ-020 overflow SHALL equal (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in progress; start in DONE is also ignored.
REQ-022 WIDTH=1 SHALL work: a single SHIFT cycle, then DONE.
REQ-023 Operand inputs SHALL be don't-care except on the start-sampling edge.

Reset
REQ-024 With rst=1 on an edge:
  - FSM to IDLE; counter and borrow register to 0
  - diff=0, borrow_out=0, overflow=0, busy=0, done=0
REQ-025 rst SHALL take priority over start.
REQ-026 Reset mid-operation SHALL abort with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Structure
REQ-027 A shared package SHALL hold:
  - the FSM state enumeration (IDLE, SHIFT, DONE)
  - the default WIDTH constant
  - the counter-width helper, clog2 of WIDTH, minimum 1
REQ-028 The one-bit full-subtractor cell SHALL be a combinational sub-module named full_sub, with ports x, y, bin, d, bout, instantiated once.
REQ-029 No multi-bit subtract operator SHALL be used in the datapath; the result comes only from iterating full_sub.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x23, borrow_in=0, start one cycle -> done exactly 8 edges later; diff=0x37, borrow_out=0, overflow=0; busy high for 9 cycles.
REQ-031 a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, overflow=0.
REQ-032 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
REQ-033 a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0, overflow=0.
REQ-034 Second start with a=0xFF, b=0x00 pulsed at SHIFT cycle 3 of the 0x5A-0x23 operation -> ignored; result is still 0x37; exactly one done pulse.
REQ-035 rst asserted at SHIFT cycle 4 -> all outputs 0 next cycle, no done; start after release with 0x5A-0x23 -> 0x37.
